// File: rtl/alib_ri_pkg.sv
// Shared range-image pipeline definitions: fetch FSM encoding, default widths, field indices.
package alib_ri_pkg;

   localparam int unsigned FIELD_W_DEF  = 16;
   localparam int unsigned N_FIELDS_DEF = 3;
   localparam int unsigned ID_W_DEF     = 19;
   localparam int unsigned DEPTH_DEF    = 16;

   // Field positions inside a point word; field 0 sits in the LSBs.
   localparam int unsigned FLD_H = 0;
   localparam int unsigned FLD_V = 1;
   localparam int unsigned FLD_R = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } fetch_state_e;

endpackage

// File: rtl/point_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with registered occupancy and synchronous flush.
module point_sync_fifo #(
   parameter int unsigned DATA_W = 48,
   parameter int unsigned DEPTH  = 16
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_flush,
   input  logic                     i_push,
   input  logic [DATA_W-1:0]        i_data,
   input  logic                     i_pop,
   output logic [DATA_W-1:0]        o_data,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_level
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [LW-1:0]     level;
   logic              do_push;
   logic              do_pop;

   assign o_full  = (level == LW'(DEPTH));
   assign o_empty = (level == '0);
   assign o_level = level;
   assign o_data  = mem[rd_ptr];

   // A flush wins over any push/pop; overfull pushes and empty pops are dropped.
   assign do_push = i_push && !o_full && !i_flush;
   assign do_pop  = i_pop && !o_empty && !i_flush;

   // Pointer and occupancy update; pointers wrap naturally on overflow.
   always_ff @(posedge i_clk) begin
      if (i_rst || i_flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

   // Storage array; contents need no reset since occupancy gates visibility.
   always_ff @(posedge i_clk) begin
      if (do_push) mem[wr_ptr] <= i_data;
   end

endmodule

// File: rtl/point_fetch_fifo.sv
// Point-cloud fetch front end: streams points by ID from external memory into a FWFT FIFO
// and runs the frame-done handshake with the host.
module point_fetch_fifo
   import alib_ri_pkg::*;
#(
   parameter int unsigned FIELD_W    = FIELD_W_DEF,
   parameter int unsigned N_FIELDS   = N_FIELDS_DEF,
   parameter int unsigned ID_W       = ID_W_DEF,
   parameter int unsigned DEPTH      = DEPTH_DEF,
   parameter int unsigned DRAIN_DONE = 1
) (
   input  logic                           i_clk,
   input  logic                           i_rst,
   input  logic                           i_enable,
   input  logic                           i_abort,
   input  logic                           i_stall,
   input  logic [ID_W-1:0]                i_pc_size,
   output logic                           o_rd_ready,
   input  logic                           i_rd_valid,
   output logic [ID_W-1:0]                o_rd_id,
   input  logic [N_FIELDS*FIELD_W-1:0]    i_rd_data,
   output logic [N_FIELDS*FIELD_W-1:0]    o_pt_data,
   output logic                           o_pt_valid,
   input  logic                           i_pt_ready,
   output logic [$clog2(DEPTH):0]         o_level,
   output logic                           o_allpoints,
   output logic                           o_done,
   input  logic                           i_done_ack
);

   localparam int unsigned DATA_W = N_FIELDS * FIELD_W;

   fetch_state_e    state_q, state_d;
   logic [ID_W-1:0] cnt_q, cnt_d;
   logic [ID_W-1:0] size_q, size_d;
   logic            done_q, done_d;
   logic            allpts_q;
   logic            en_q;
   logic            fifo_full;
   logic            fifo_empty;
   logic            hs;
   logic            last_pt;

   // Ready follows registered occupancy only, so a same-cycle pop never reopens it.
   assign o_rd_ready  = (state_q == ST_FETCH) && !fifo_full;
   assign hs          = o_rd_ready && i_rd_valid && !i_abort;
   assign last_pt     = (cnt_q == size_q - ID_W'(1));
   assign o_rd_id     = cnt_q;
   assign o_done      = done_q;
   assign o_allpoints = allpts_q;
   assign o_pt_valid  = !fifo_empty;

   point_sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_flush (i_abort),
      .i_push  (hs),
      .i_data  (i_rd_data),
      .i_pop   (i_pt_ready),
      .o_data  (o_pt_data),
      .o_full  (fifo_full),
      .o_empty (fifo_empty),
      .o_level (o_level)
   );

   // Next-state, counter, size latch and done handshake.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      size_d  = size_q;
      done_d  = done_q;
      if (i_abort) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         done_d  = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (i_enable && !en_q) begin
                  size_d  = i_pc_size;
                  cnt_d   = '0;
                  state_d = (i_pc_size == '0) ? ST_DONE : ST_FETCH;
               end
            end
            ST_FETCH: begin
               if (hs) begin
                  cnt_d = cnt_q + ID_W'(1);
                  if (last_pt) state_d = (DRAIN_DONE != 0) ? ST_DRAIN : ST_DONE;
               end
            end
            ST_DRAIN: begin
               if (fifo_empty) state_d = ST_DONE;
            end
            ST_DONE: begin
               if (done_q) begin
                  if (i_done_ack) begin
                     done_d  = 1'b0;
                     state_d = ST_IDLE;
                  end
               end else if (!i_stall) begin
                  done_d = 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Control registers; all-points flag tracks the next counter/size pair.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         size_q   <= '0;
         done_q   <= 1'b0;
         allpts_q <= 1'b1;
         en_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         size_q   <= size_d;
         done_q   <= done_d;
         allpts_q <= (cnt_d == size_d);
         en_q     <= i_enable;
      end
   end

endmodule
